// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue slice.
//   - ALU op encodings driven on alu_op
//   - RV64I major opcodes recognised by the decoder
//   - issue FSM state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;  // unsigned in1 < in2
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Branch outcome source
    localparam logic [1:0] BR_Z   = 2'd0;  // taken = zflag
    localparam logic [1:0] BR_NZ  = 2'd1;  // taken = ~zflag
    localparam logic [1:0] BR_LT  = 2'd2;  // taken = out[0]
    localparam logic [1:0] BR_NLT = 2'd3;  // taken = ~out[0]

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV64I field decode for the ALU issue FSM.
//   in : opcode[6:0], funct3[2:0], funct7_5
//   out: illegal   - unsupported encoding, skip straight to response
//        is_xor    - three-pass XOR sequence (AND, NOR, NOR)
//        use_imm   - second operand from imm instead of rs2
//        sflip     - signed compare: invert bit 63 of both operands
//        is_branch - result is a taken flag, data result is 0
//        br_sel    - which flag forms the branch outcome
//        op        - ALU op for single-pass instructions
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       illegal,
    output logic       is_xor,
    output logic       use_imm,
    output logic       sflip,
    output logic       is_branch,
    output logic [1:0] br_sel,
    output logic [3:0] op
);

    always_comb begin
        illegal   = 1'b0;
        is_xor    = 1'b0;
        use_imm   = 1'b0;
        sflip     = 1'b0;
        is_branch = 1'b0;
        br_sel    = BR_Z;
        op        = ALU_AND;
        case (opcode)
            OPC_OPIMM, OPC_OP: begin
                use_imm = (opcode == OPC_OPIMM);
                case (funct3)
                    3'b000:  op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  begin op = ALU_SLT; sflip = 1'b1; end
                    3'b011:  op = ALU_SLT;
                    3'b100:  is_xor = 1'b1;
                    3'b110:  op = ALU_OR;
                    3'b111:  op = ALU_AND;
                    default: illegal = 1'b1;  // shifts not supported
                endcase
                // funct7_5 only selects SUB; on OP it is otherwise reserved
                if (opcode == OPC_OP && funct7_5 && funct3 != 3'b000)
                    illegal = 1'b1;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                case (funct3)
                    3'b000:  begin op = ALU_SUB; br_sel = BR_Z;   end
                    3'b001:  begin op = ALU_SUB; br_sel = BR_NZ;  end
                    3'b100:  begin op = ALU_SLT; br_sel = BR_LT;  sflip = 1'b1; end
                    3'b101:  begin op = ALU_SLT; br_sel = BR_NLT; sflip = 1'b1; end
                    3'b110:  begin op = ALU_SLT; br_sel = BR_LT;  end
                    3'b111:  begin op = ALU_SLT; br_sel = BR_NLT; end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: sequences RV64I integer ops onto an external 64-bit ALU that
// only knows AND/OR/ADD/SUB/SLT/NOR. XOR is built from three passes, signed
// compares by flipping operand MSBs.
//   clk, rst_n                 - clock, async active-low reset
//   req_valid/req_ready        - request handshake (ready only in IDLE)
//   opcode, funct3, funct7_5   - instruction fields
//   rs1_val, rs2_val, imm      - operands (imm already sign-extended)
//   alu_in1, alu_in2, alu_op   - to external ALU
//   alu_out, alu_zflag         - from external ALU, same cycle
//   rsp_valid/rsp_ready        - response handshake
//   rsp_result, rsp_taken, rsp_illegal - response payload
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [63:0] rs1_val,
    input  logic [63:0] rs2_val,
    input  logic [63:0] imm,
    output logic [63:0] alu_in1,
    output logic [63:0] alu_in2,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_out,
    input  logic        alu_zflag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_taken,
    output logic        rsp_illegal
);

    state_t      state;
    logic [63:0] a_q, b_q, t1_q, t2_q;
    logic        xor_q, br_q;
    logic [1:0]  brsel_q;
    logic [3:0]  op_q;

    logic        d_illegal, d_xor, d_imm, d_sflip, d_branch;
    logic [1:0]  d_brsel;
    logic [3:0]  d_op;
    logic [63:0] flip;

    alu_issue_decode u_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .illegal   (d_illegal),
        .is_xor    (d_xor),
        .use_imm   (d_imm),
        .sflip     (d_sflip),
        .is_branch (d_branch),
        .br_sel    (d_brsel),
        .op        (d_op)
    );

    // Signed compare folded into operand capture so the ALU always sees an
    // unsigned SLT.
    assign flip      = {d_sflip, 63'd0};
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        alu_op  = ALU_AND;
        alu_in1 = '0;
        alu_in2 = '0;
        case (state)
            S_P1: begin alu_op = xor_q ? ALU_AND : op_q; alu_in1 = a_q;  alu_in2 = b_q;  end
            S_P2: begin alu_op = ALU_NOR;                alu_in1 = a_q;  alu_in2 = b_q;  end
            S_P3: begin alu_op = ALU_NOR;                alu_in1 = t1_q; alu_in2 = t2_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            xor_q       <= 1'b0;
            br_q        <= 1'b0;
            brsel_q     <= BR_Z;
            op_q        <= ALU_AND;
            rsp_result  <= '0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    if (d_illegal) begin
                        rsp_result  <= '0;
                        rsp_taken   <= 1'b0;
                        rsp_illegal <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        a_q         <= rs1_val ^ flip;
                        b_q         <= (d_imm ? imm : rs2_val) ^ flip;
                        xor_q       <= d_xor;
                        br_q        <= d_branch;
                        brsel_q     <= d_brsel;
                        op_q        <= d_op;
                        rsp_illegal <= 1'b0;
                        state       <= S_P1;
                    end
                end
                S_P1: begin
                    if (xor_q) begin
                        t1_q  <= alu_out;
                        state <= S_P2;
                    end else begin
                        if (br_q) begin
                            rsp_result <= '0;
                            case (brsel_q)
                                BR_Z:    rsp_taken <= alu_zflag;
                                BR_NZ:   rsp_taken <= ~alu_zflag;
                                BR_LT:   rsp_taken <= alu_out[0];
                                default: rsp_taken <= ~alu_out[0];
                            endcase
                        end else begin
                            rsp_result <= alu_out;
                            rsp_taken  <= 1'b0;
                        end
                        state <= S_RESP;
                    end
                end
                S_P2: begin
                    t2_q  <= alu_out;
                    state <= S_P3;
                end
                S_P3: begin
                    rsp_result <= alu_out;
                    rsp_taken  <= 1'b0;
                    state      <= S_RESP;
                end
                S_RESP: if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have req_valid in 1, req_ready out 1: request handshake; transfer when both high on a clk edge.
REQ-004 SHALL have opcode in 7, funct3 in 3, funct7_5 in 1: RV64I instruction fields.
REQ-005 SHALL have rs1_val in 64, rs2_val in 64, imm in 64 (pre-sign-extended immediate).
REQ-006 SHALL have alu_in1 out 64, alu_in2 out 64, alu_op out 4: drive the 64-bit ALU operand/op ports.
REQ-007 SHALL have alu_out in 64, alu_zflag in 1: ALU result and zero flag, combinational in the same cycle.
REQ-008 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_result out 64, rsp_taken out 1, rsp_illegal out 1.

Function
REQ-009 ALU op encodings SHALL be AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (unsigned in1<in2 -> 1), NOR 1100; no other value ever driven.
REQ-010 FSM states SHALL be IDLE, P1, P2, P3, RESP; req_ready=1 only in IDLE.
REQ-011 On accept, SHALL capture operands: in2 = imm for OP-IMM (0010011), rs2_val for OP (0110011) and BRANCH (1100011); in1 = rs1_val.
REQ-012 Each of P1..P3 SHALL present one ALU pass; alu_out/alu_zflag SHALL be registered at end of that cycle.
REQ-013 Single-pass ops SHALL be: ADD/ADDI (ADD), SUB (OP, funct3 000, funct7_5=1), AND/ANDI, OR/ORI, SLTU/SLTIU (SLT), SLT/SLTI (SLT with bit 63 of both operands inverted).
REQ-014 XOR/XORI SHALL take three passes: P1 AND(a,b)->t1, P2 NOR(a,b)->t2, P3 NOR(t1,t2) -> result.
REQ-015 Branches SHALL be single-pass: BEQ/BNE SUB, taken = zflag / ~zflag; BLT/BGE signed SLT (MSB-flipped), BLTU/BGEU SLT, taken = out[0] / ~out[0]; rsp_result = 0 for branches.
REQ-016 Illegal SHALL be: any other opcode, funct3 001/101 (shifts), branch funct3 010/011, OP funct7_5=1 with funct3 != 000; illegal goes IDLE -> RESP directly, result 0, taken 0, rsp_illegal 1.
REQ-017 ADDI/ANDI/ORI/XORI/SLTI/SLTIU SHALL ignore funct7_5.
REQ-018 Latency SHALL be: accept at edge N, rsp_valid high after edge N+2 for single-pass, N+4 for XOR, N+1 for illegal.
REQ-019 In IDLE and RESP, alu_op SHALL be AND and alu_in1/alu_in2 SHALL be 0.
REQ-020 In RESP, rsp_* SHALL hold stable until rsp_ready high on an edge, then FSM -> IDLE (no same-edge accept).
REQ-021 rsp_valid SHALL be 0 in all states except RESP.
REQ-022 Arithmetic SHALL wrap modulo 2^64; no overflow output.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, rsp_valid 0, rsp_result 0, rsp_taken 0, rsp_illegal 0, all operand/temp registers 0.
REQ-024 Reset mid-operation SHALL discard the in-flight request; no response is produced for it.
REQ-025 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package alu_pkg SHALL hold ALU op constants, RV64I opcode constants, and the FSM state enum.
REQ-027 Combinational decode (fields -> op sequence, pass count, operand select, compare/branch mode, illegal) SHALL be sub-module alu_issue_decode.
REQ-028 The ALU itself SHALL NOT be instantiated inside; the bench connects a reference ALU model.

Verification
REQ-029 ADDI rs1=0xFFFF_FFFF_FFFF_FFFF imm=1 -> rsp_result 0, rsp_valid 2 cycles after accept.
REQ-030 XOR rs1=0xF0F0 rs2=0x0FF0 -> alu_op sequence AND, NOR, NOR; rsp_result 0xFF00 at 4 cycles.
REQ-031 BLT rs1=-1 rs2=1 -> taken 1; BLTU same operands -> taken 0; BEQ 5,5 -> taken 1.
REQ-032 SLLI (funct3 001) -> rsp_illegal 1, result 0, 1 cycle latency, alu_op stays AND.
REQ-033 rsp_ready held low 5 cycles -> rsp_* stable, req_ready 0; release -> IDLE next cycle.
REQ-034 rst_n pulsed low during XOR P2 -> rsp_valid 0 immediately, req_ready 1 after release, no response emitted.
